pads_cfg_sequencer: RTL and testbench
=====================================

# pads_cfg_sequencer

Programs the pad direction-control stage by generating its `cnfg_io` / `cnfg_en` inputs. Software writes the desired per-pad direction values and an update mask into shadow registers, then issues a commit. The block applies the update in staggered pad groups, with idle gaps between groups, so that no more than `GROUP` pads change direction in the same cycle (SSO / ground-bounce control). It sits directly upstream of the 44-pad direction register and uses the same clock and reset.

## Interface
Parameters:
- `NUM_PADS`, 44, number of pads; must be even.
- `GROUP`, 8, maximum pads enabled per apply cycle; legal range 1..`NUM_PADS`.
- `GAP`, 2, idle cycles between consecutive groups; 0 is legal.

Ports (clock and reset first; one clock, reset is asynchronous and active-low):
- `clk` in 1: the only clock.
- `resetb` in 1: asynchronous active-low reset.
- `wr_valid` in 1: shadow write request.
- `wr_ready` out 1: write accepted when high together with `wr_valid`.
- `wr_addr` in 2: shadow write target. 0 = io[21:0], 1 = io[43:22], 2 = mask[21:0], 3 = mask[43:22].
- `wr_data` in `NUM_PADS/2`: write data (22 bits by default).
- `commit` in 1: start-apply pulse.
- `busy` out 1: an apply sequence is in progress.
- `done` out 1: one-cycle pulse when a sequence completes.
- `cnfg_io` out `NUM_PADS`: direction values; 1 = input, 0 = output.
- `cnfg_en` out `NUM_PADS`: per-pad load strobes.

## Operation
Shadow registers:
- `io_sh` resets to `44'hC70003FFFBD`, the pad default direction pattern.
- `mask_sh` resets to all zeros.

Outputs:
- `cnfg_io` is driven directly from `io_sh` at all times.
- `cnfg_en` is a registered output and is zero outside the APPLY state.

Write handshake:
- `wr_ready` = (state == IDLE).
- A write completes on any edge where `wr_valid` and `wr_ready` are both high.
- A write updates the addressed half only.

FSM states: IDLE, APPLY, WAIT, DONE. The group counter `g` runs from 0 to NG-1, where NG = ceil(`NUM_PADS`/`GROUP`) (6 by default).
- IDLE: if `commit` is high, set `g` = 0 and go to APPLY.
- APPLY: `cnfg_en` = `mask_sh` restricted to pad indices [g·GROUP, min((g+1)·GROUP, NUM_PADS)−1]. The last group is partial: pads 40..43 by default.
  - If g == NG−1, go to DONE.
  - Else if `GAP` == 0, increment `g` and stay in APPLY.
  - Else go to WAIT.
- WAIT: count `GAP` cycles, then increment `g` and go to APPLY.
- DONE: `done` = 1 for one cycle, then go to IDLE.

Boundary conditions:
- `commit` outside IDLE is ignored; it is not queued.
- A write and `commit` in the same IDLE cycle: the write lands first, and the sequence applies the post-write shadow.
- A masked-off group still consumes its APPLY cycle and its gap, with `cnfg_en` all zero.
- A `mask_sh` of all zeros still runs the full sequence and pulses `done`.
- Reset asserted mid-sequence immediately forces IDLE, `cnfg_en` = 0, `busy` = 0, `done` = 0 and shadows to their reset values. Pads already updated keep their new values downstream; that is the downstream block's reset behaviour, not this block's.

## Timing
Reset values:
- `wr_ready` = 1, `busy` = 0, `done` = 0, `cnfg_en` = 0, `cnfg_io` = `44'hC70003FFFBD`.

Sequence timing:
- `commit` is sampled at edge N; `cnfg_en` for group 0 is high during cycle N+1.
- Group k's strobe starts at cycle N+1+k·(1+`GAP`).
- DONE occupies the cycle after the last APPLY. With defaults, `done` is high in cycle N+17.
- `busy` is high from APPLY through DONE inclusive (17 cycles by default), so `busy` = !`wr_ready`.

Downstream interaction:
- `cnfg_io` is stable for the whole sequence, because writes are blocked while busy.
- The downstream stage captures `cnfg_io` on the same edge that ends each strobe cycle.

## Configuration
`PADS_CFG_LOCK_EN`:
- Defined: pads 38..41 (clock, flash_csb, flash_clk, flash_io0) are locked. Their `mask_sh` bits are forced to 0 on write and at reset, so `cnfg_en[41:38]` is never asserted, and their `io_sh` bits stay at the reset value.
- Undefined: all `NUM_PADS` pads are fully programmable.

## Test plan
- Reset, then idle: `cnfg_io` = `44'hC70003FFFBD`, `cnfg_en` = 0, `wr_ready` = 1, `busy` = 0.
- Write mask = all ones and io = 0, then commit → `cnfg_en` sequence `0xFF`, `0xFF00`, …, `0xF<<40` at cycles N+1, N+4, …, N+16 → `done` at N+17 → `busy` low at N+18.
- With `GAP` = 0 and mask = `44'h1`, commit → `cnfg_en` = 1 at N+1 only; groups 1..5 are zero; `done` at N+7.
- `wr_valid` and `commit` during busy → `wr_ready` stays 0, the shadow is unchanged, and there is no second `done` pulse.
- Reset pulsed at group 3 → outputs return to reset values within the reset assertion; a fresh commit afterward restarts from group 0.
- With `PADS_CFG_LOCK_EN`: mask = all ones, commit → bits 41:38 of `cnfg_en` are never 1; without it they pulse at N+13 (38, 39) and N+16 (40, 41).

Source files
------------

// File: rtl/pads_cfg_sequencer.sv
// pads_cfg_sequencer
//   Holds shadow copies of the pad direction values and an update mask, and on
//   commit replays the mask onto cnfg_en in staggered groups of at most GROUP
//   pads, with GAP idle cycles between groups, to limit simultaneous switching.
//
// Ports
//   clk        : clock
//   resetb     : asynchronous active-low reset
//   wr_valid   : shadow write request
//   wr_ready   : write accepted (high only while idle)
//   wr_addr    : 0 io low half, 1 io high half, 2 mask low half, 3 mask high half
//   wr_data    : write data, NUM_PADS/2 bits
//   commit     : start-apply pulse, honoured only while idle
//   busy       : apply sequence in progress (APPLY through DONE)
//   done       : one-cycle pulse when a sequence completes
//   cnfg_io    : direction values (1 = input, 0 = output), straight from io_sh
//   cnfg_en    : registered per-pad load strobes
//
// Build option
//   PADS_CFG_LOCK_EN : when defined, pads 38..41 are locked; their mask bits
//                      are held at 0 and their io bits at the reset pattern.
module pads_cfg_sequencer #(
    parameter int unsigned NUM_PADS = 44,
    parameter int unsigned GROUP    = 8,
    parameter int unsigned GAP      = 2
) (
    input  logic                    clk,
    input  logic                    resetb,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [1:0]              wr_addr,
    input  logic [NUM_PADS/2-1:0]   wr_data,
    input  logic                    commit,
    output logic                    busy,
    output logic                    done,
    output logic [NUM_PADS-1:0]     cnfg_io,
    output logic [NUM_PADS-1:0]     cnfg_en
);

    localparam int unsigned HALF = NUM_PADS / 2;
    localparam int unsigned NG   = (NUM_PADS + GROUP - 1) / GROUP;
    localparam int unsigned GW   = (NG > 1) ? $clog2(NG) : 1;
    localparam int unsigned CW   = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [NUM_PADS-1:0] IO_RST = NUM_PADS'(44'hC70003FFFBD);
`ifdef PADS_CFG_LOCK_EN
    localparam logic [NUM_PADS-1:0] LOCK = NUM_PADS'(44'h3C000000000);
`else
    localparam logic [NUM_PADS-1:0] LOCK = '0;
`endif

    typedef enum logic [1:0] {IDLE, APPLY, WAIT, DONE} state_t;

    state_t              state;
    logic [GW-1:0]       g;
    logic [CW-1:0]       wcnt;
    logic [NUM_PADS-1:0] io_sh;
    logic [NUM_PADS-1:0] mask_sh;
    logic [NUM_PADS-1:0] io_nx;
    logic [NUM_PADS-1:0] mask_nx;
    logic                wr_fire;

    // Pads belonging to group k; the last group naturally truncates at NUM_PADS.
    function automatic logic [NUM_PADS-1:0] grp_sel(input logic [GW-1:0] k);
        logic [NUM_PADS-1:0] sel;
        sel = '0;
        for (int unsigned i = 0; i < NUM_PADS; i++)
            sel[i] = ((i / GROUP) == 32'(k));
        return sel;
    endfunction

    assign wr_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign cnfg_io  = io_sh;
    assign wr_fire  = wr_valid && wr_ready;

    // Post-write shadow view: group 0 is loaded from this so a write issued
    // in the same cycle as commit is already reflected in the first strobe.
    always_comb begin
        io_nx   = io_sh;
        mask_nx = mask_sh;
        if (wr_fire) begin
            case (wr_addr)
                2'd0:    io_nx[HALF-1:0]          = wr_data;
                2'd1:    io_nx[NUM_PADS-1:HALF]   = wr_data;
                2'd2:    mask_nx[HALF-1:0]        = wr_data;
                default: mask_nx[NUM_PADS-1:HALF] = wr_data;
            endcase
        end
        io_nx   = (io_nx & ~LOCK) | (IO_RST & LOCK);
        mask_nx = mask_nx & ~LOCK;
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state   <= IDLE;
            g       <= '0;
            wcnt    <= '0;
            cnfg_en <= '0;
            done    <= 1'b0;
            io_sh   <= IO_RST;
            mask_sh <= '0;
        end else begin
            io_sh   <= io_nx;
            mask_sh <= mask_nx;
            done    <= 1'b0;
            cnfg_en <= '0;
            case (state)
                IDLE: begin
                    if (commit) begin
                        g       <= '0;
                        state   <= APPLY;
                        cnfg_en <= mask_nx & grp_sel('0);
                    end
                end
                APPLY: begin
                    if (g == GW'(NG - 1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else if (GAP == 0) begin
                        g       <= g + 1'b1;
                        cnfg_en <= mask_sh & grp_sel(g + 1'b1);
                    end else begin
                        wcnt  <= '0;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (wcnt == CW'(GAP - 1)) begin
                        g       <= g + 1'b1;
                        state   <= APPLY;
                        cnfg_en <= mask_sh & grp_sel(g + 1'b1);
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pads_cfg_sequencer.sv
// tb_pads_cfg_sequencer
//   Two instances: index 0 uses the default GAP of 2, index 1 uses GAP = 0.
//   Expected strobes come from a cycle-offset model of the shadow registers.
module tb_pads_cfg_sequencer;

    localparam logic [43:0] IO_RST = 44'hC70003FFFBD;
`ifdef PADS_CFG_LOCK_EN
    localparam logic [43:0] LOCK = 44'h3C000000000;
`else
    localparam logic [43:0] LOCK = 44'h0;
`endif

    logic             clk = 1'b0;
    logic             resetb;
    logic [1:0]       wr_valid;
    logic [1:0]       commit;
    logic [1:0][1:0]  wr_addr;
    logic [1:0][21:0] wr_data;
    logic [1:0]       wr_ready;
    logic [1:0]       busy;
    logic [1:0]       done;
    logic [1:0][43:0] cnfg_io;
    logic [1:0][43:0] cnfg_en;

    logic [43:0] io_m   [2];
    logic [43:0] mask_m [2];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pads_cfg_sequencer #(.NUM_PADS(44), .GROUP(8), .GAP(2)) dut0 (
        .clk(clk), .resetb(resetb),
        .wr_valid(wr_valid[0]), .wr_ready(wr_ready[0]),
        .wr_addr(wr_addr[0]), .wr_data(wr_data[0]),
        .commit(commit[0]), .busy(busy[0]), .done(done[0]),
        .cnfg_io(cnfg_io[0]), .cnfg_en(cnfg_en[0])
    );

    pads_cfg_sequencer #(.NUM_PADS(44), .GROUP(8), .GAP(0)) dut1 (
        .clk(clk), .resetb(resetb),
        .wr_valid(wr_valid[1]), .wr_ready(wr_ready[1]),
        .wr_addr(wr_addr[1]), .wr_data(wr_data[1]),
        .commit(commit[1]), .busy(busy[1]), .done(done[1]),
        .cnfg_io(cnfg_io[1]), .cnfg_en(cnfg_en[1])
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int gap_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    // Cycle (counted from the commit edge) in which done is high.
    function automatic int last_t(input int d);
        return 2 + 5 * (gap_of(d) + 1);
    endfunction

    function automatic logic [43:0] grp_bits(input int k);
        logic [43:0] b = '0;
        for (int i = 0; i < 44; i++)
            if (i >= k * 8 && i < (k + 1) * 8) b[i] = 1'b1;
        return b;
    endfunction

    function automatic logic [43:0] exp_en(input int d, input int t);
        int p = gap_of(d) + 1;
        if (t >= 1 && (t - 1) % p == 0 && (t - 1) / p < 6)
            return mask_m[d] & grp_bits((t - 1) / p);
        return '0;
    endfunction

    task automatic model_write(input int d, input logic [1:0] a, input logic [21:0] v);
        case (a)
            2'd0: io_m[d][21:0]    = v;
            2'd1: io_m[d][43:22]   = v;
            2'd2: mask_m[d][21:0]  = v;
            2'd3: mask_m[d][43:22] = v;
        endcase
        io_m[d]   = (io_m[d] & ~LOCK) | (IO_RST & LOCK);
        mask_m[d] = mask_m[d] & ~LOCK;
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            io_m[d]   = IO_RST;
            mask_m[d] = '0;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk({tag, "_io"},    cnfg_io[d],  IO_RST);
            chk({tag, "_en"},    cnfg_en[d],  44'h0);
            chk({tag, "_ready"}, wr_ready[d], 1);
            chk({tag, "_busy"},  busy[d],     0);
            chk({tag, "_done"},  done[d],     0);
        end
    endtask

    // Idle write; entered and left just after a rising edge.
    task automatic wr(input int d, input logic [1:0] a, input logic [21:0] v);
        wr_valid[d] = 1'b1;
        wr_addr[d]  = a;
        wr_data[d]  = v;
        @(posedge clk);
        #1;
        wr_valid[d] = 1'b0;
        model_write(d, a, v);
        chk("wr_io", cnfg_io[d], io_m[d]);
    endtask

    // Commit (optionally with a same-cycle write) and follow the whole sequence.
    // disturb: hold wr_valid/commit high while busy. rst_at: cycle to pulse reset.
    task automatic run_seq(input int d, input bit with_wr, input logic [1:0] a,
                           input logic [21:0] v, input bit disturb, input int rst_at);
        int T = last_t(d);
        commit[d] = 1'b1;
        if (with_wr) begin
            wr_valid[d] = 1'b1;
            wr_addr[d]  = a;
            wr_data[d]  = v;
        end
        @(posedge clk);
        #1;
        commit[d]   = 1'b0;
        wr_valid[d] = 1'b0;
        if (with_wr) model_write(d, a, v);
        for (int t = 1; t <= T + 1; t++) begin
            @(negedge clk);
            chk("en",    cnfg_en[d],  exp_en(d, t));
            chk("done",  done[d],     (t == T));
            chk("busy",  busy[d],     (t <= T));
            chk("ready", wr_ready[d], (t > T));
            chk("io",    cnfg_io[d],  io_m[d]);
            if (t == rst_at) begin
                resetb = 1'b0;
                #1;
                check_reset_vals("rst_mid");
                model_reset();
                @(posedge clk);
                @(negedge clk);
                resetb = 1'b1;
                @(posedge clk);
                #1;
                return;
            end
            if (disturb && t == 2) begin
                commit[d]   = 1'b1;
                wr_valid[d] = 1'b1;
                wr_addr[d]  = 2'($urandom);
                wr_data[d]  = 22'($urandom);
            end
            if (disturb && t == T) begin
                commit[d]   = 1'b0;
                wr_valid[d] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout CHECKS %0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        resetb   = 1'b0;
        wr_valid = '0;
        commit   = '0;
        wr_addr  = '0;
        wr_data  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        @(negedge clk);
        resetb = 1'b1;
        @(posedge clk);
        #1;
        check_reset_vals("idle");

        // Full mask, io all outputs, default gap.
        wr(0, 2'd2, 22'h3FFFFF);
        wr(0, 2'd3, 22'h3FFFFF);
        wr(0, 2'd0, 22'h0);
        wr(0, 2'd1, 22'h0);
        run_seq(0, 1'b0, 2'd0, 22'h0, 1'b0, -1);

        // Single-pad mask, zero gap.
        wr(1, 2'd2, 22'h1);
        wr(1, 2'd3, 22'h0);
        run_seq(1, 1'b0, 2'd0, 22'h0, 1'b0, -1);

        // Writes and commits while busy are dropped.
        run_seq(0, 1'b0, 2'd0, 22'h0, 1'b1, -1);
        run_seq(1, 1'b0, 2'd0, 22'h0, 1'b1, -1);

        // Reset during group 3, then a fresh full sequence.
        run_seq(0, 1'b0, 2'd0, 22'h0, 1'b0, 10);
        check_reset_vals("after_rst");
        wr(0, 2'd2, 22'h3FFFFF);
        wr(0, 2'd3, 22'h3FFFFF);
        run_seq(0, 1'b0, 2'd0, 22'h0, 1'b0, -1);

        // Write in the commit cycle lands first.
        run_seq(0, 1'b1, 2'd2, 22'h2AAAAA, 1'b0, -1);
        run_seq(1, 1'b1, 2'd3, 22'h155555, 1'b0, -1);

        // All-zero mask still runs to done.
        wr(0, 2'd2, 22'h0);
        wr(0, 2'd3, 22'h0);
        run_seq(0, 1'b0, 2'd0, 22'h0, 1'b0, -1);

        // Randomised traffic.
        repeat (16) begin
            int d = int'($urandom_range(0, 1));
            int n = int'($urandom_range(0, 3));
            for (int i = 0; i < n; i++)
                wr(d, 2'($urandom), 22'($urandom));
            run_seq(d, 1'($urandom), 2'($urandom), 22'($urandom), 1'($urandom), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
